// File: rtl/execute_mc.sv
// execute_mc: multi-cycle execute unit with registered outputs, a valid/ready
// input handshake, an iterative shift-add multiplier and an optional
// restoring divider sharing the HI/LO pair.
// Build option: define EXEC_DIV_EN to compile in the DIV state, the divider
// datapath and div/divu decoding. Without it, div/divu decode as unsupported.
//
// state | meaning
// IDLE  | ready; single-cycle ops complete here, mult/div start here
// MUL   | one multiplier bit per cycle, WIDTH iterations
// DIV   | one quotient bit per cycle, WIDTH iterations (EXEC_DIV_EN only)
module execute_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] pc4,
   input  logic [WIDTH-1:0] register_rs,
   input  logic [WIDTH-1:0] register_rt,
   input  logic [WIDTH-1:0] sign_extend,
   input  logic [5:0]       function_opcode,
   input  logic [1:0]       aluop,
   input  logic             alusrc,
   input  logic             regdst,
   input  logic             branch,
   input  logic [4:0]       wreg_rd,
   input  logic [4:0]       wreg_rt,
   output logic             out_valid,
   output logic [WIDTH-1:0] alu_result,
   output logic [WIDTH-1:0] branch_addr,
   output logic [4:0]       wreg_address,
   output logic             do_branch
);
   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLTU = 6'b101011;
   localparam logic [5:0] F_MFHI = 6'b010000;
   localparam logic [5:0] F_MFLO = 6'b010010;

`ifdef EXEC_DIV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1} state_t;
`endif

   state_t state, state_nxt;

   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   hi, lo;
   logic [WIDTH-1:0]   b_op, diff, alu_comb, a_mag, b_mag, baddr_comb;
   logic               accept, is_mul, is_div, op_signed, last_iter, dob_comb, neg_res;
   logic [2*WIDTH-1:0] prod, prod_nxt, prod_fin;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   pend_baddr;
   logic               pend_dob;
`ifdef EXEC_DIV_EN
   logic [WIDTH-1:0]   rem, quo, dvsr, r_nxt, q_nxt, lo_div, hi_div;
   logic [WIDTH:0]     r_sh;
   logic               ge, neg_r, dz;
`endif

   // Operand mux, decode and the single-cycle result/branch terms.
   always_comb begin
      b_op       = alusrc ? sign_extend : register_rt;
      diff       = register_rs - b_op;
      accept     = in_valid && in_ready;
      is_mul     = (aluop == 2'b10) && (function_opcode[5:1] == 5'b01100);
`ifdef EXEC_DIV_EN
      is_div     = (aluop == 2'b10) && (function_opcode[5:1] == 5'b01101);
`else
      is_div     = 1'b0;
`endif
      op_signed  = ~function_opcode[0];
      a_mag      = (op_signed && register_rs[WIDTH-1]) ? -register_rs : register_rs;
      b_mag      = (op_signed && b_op[WIDTH-1]) ? -b_op : b_op;
      baddr_comb = pc4 + (sign_extend << 2);
      dob_comb   = branch && (diff == '0);
      last_iter  = (cnt == CW'(1));
      alu_comb   = '0;
      case (aluop)
         2'b00: alu_comb = register_rs + b_op;
         2'b01: alu_comb = diff;
         2'b10: begin
            case (function_opcode)
               F_ADD:   alu_comb = register_rs + b_op;
               F_SUB:   alu_comb = diff;
               F_AND:   alu_comb = register_rs & b_op;
               F_OR:    alu_comb = register_rs | b_op;
               F_SLT:   alu_comb = {{(WIDTH-1){1'b0}}, ($signed(register_rs) < $signed(b_op))};
               F_SLTU:  alu_comb = {{(WIDTH-1){1'b0}}, (register_rs < b_op)};
               F_MFHI:  alu_comb = hi;
               F_MFLO:  alu_comb = lo;
               default: alu_comb = '0;
            endcase
         end
         default: alu_comb = '0;
      endcase
   end

   // One multiplier step: add multiplicand into the upper half when the
   // current multiplier bit is set, then shift the whole product right.
   always_comb begin
      mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      prod_nxt = {mul_sum, prod[WIDTH-1:1]};
      prod_fin = neg_res ? -prod_nxt : prod_nxt;
   end

`ifdef EXEC_DIV_EN
   // One restoring-divide step; a zero divisor leaves the dividend in the
   // remainder, so only LO needs special handling on completion.
   always_comb begin
      r_sh   = {rem, quo[WIDTH-1]};
      ge     = r_sh >= {1'b0, dvsr};
      r_nxt  = ge ? (r_sh[WIDTH-1:0] - dvsr) : r_sh[WIDTH-1:0];
      q_nxt  = {quo[WIDTH-2:0], ge};
      lo_div = dz ? '1 : (neg_res ? -q_nxt : q_nxt);
      hi_div = neg_r ? -r_nxt : r_nxt;
   end
`endif

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && is_mul)
               state_nxt = MUL;
`ifdef EXEC_DIV_EN
            else if (accept && is_div)
               state_nxt = DIV;
`endif
         end
         MUL: if (last_iter) state_nxt = IDLE;
`ifdef EXEC_DIV_EN
         DIV: if (last_iter) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   assign in_ready = (state == IDLE);

   // Datapath, HI/LO and registered outputs; branch terms of a mult/div are
   // parked until completion so outputs hold between pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt          <= '0;
         hi           <= '0;
         lo           <= '0;
         prod         <= '0;
         mcand        <= '0;
         neg_res      <= 1'b0;
         pend_baddr   <= '0;
         pend_dob     <= 1'b0;
         out_valid    <= 1'b0;
         alu_result   <= '0;
         branch_addr  <= '0;
         wreg_address <= '0;
         do_branch    <= 1'b0;
`ifdef EXEC_DIV_EN
         rem          <= '0;
         quo          <= '0;
         dvsr         <= '0;
         neg_r        <= 1'b0;
         dz           <= 1'b0;
`endif
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_mul || is_div) begin
                     cnt        <= CW'(WIDTH);
                     pend_baddr <= baddr_comb;
                     pend_dob   <= dob_comb;
                     prod       <= {{WIDTH{1'b0}}, b_mag};
                     mcand      <= a_mag;
                     neg_res    <= op_signed && (register_rs[WIDTH-1] ^ b_op[WIDTH-1]);
`ifdef EXEC_DIV_EN
                     rem        <= '0;
                     quo        <= a_mag;
                     dvsr       <= b_mag;
                     neg_r      <= op_signed && register_rs[WIDTH-1];
                     dz         <= (b_op == '0);
`endif
                  end else begin
                     out_valid    <= 1'b1;
                     alu_result   <= alu_comb;
                     branch_addr  <= baddr_comb;
                     do_branch    <= dob_comb;
                     wreg_address <= regdst ? wreg_rd : wreg_rt;
                  end
               end
            end
            MUL: begin
               cnt  <= cnt - CW'(1);
               prod <= prod_nxt;
               if (last_iter) begin
                  {hi, lo}     <= prod_fin;
                  alu_result   <= prod_fin[WIDTH-1:0];
                  out_valid    <= 1'b1;
                  branch_addr  <= pend_baddr;
                  do_branch    <= pend_dob;
                  wreg_address <= '0;
               end
            end
`ifdef EXEC_DIV_EN
            DIV: begin
               cnt <= cnt - CW'(1);
               rem <= r_nxt;
               quo <= q_nxt;
               if (last_iter) begin
                  hi           <= hi_div;
                  lo           <= lo_div;
                  alu_result   <= lo_div;
                  out_valid    <= 1'b1;
                  branch_addr  <= pend_baddr;
                  do_branch    <= pend_dob;
                  wreg_address <= '0;
               end
            end
`endif
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_execute_mc.sv
// Randomized self-checking bench for execute_mc (WIDTH = 32). Expected
// results come from a 64-bit arithmetic reference model and a queue of
// expected completion cycles.
module tb_execute_mc;
   localparam int W = 32;

   logic          clock = 1'b0;
   logic          reset_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  pc4 = '0, register_rs = '0, register_rt = '0, sign_extend = '0;
   logic [5:0]    function_opcode = '0;
   logic [1:0]    aluop = '0;
   logic          alusrc = 1'b0, regdst = 1'b0, branch = 1'b0;
   logic [4:0]    wreg_rd = '0, wreg_rt = '0;
   logic          out_valid;
   logic [W-1:0]  alu_result, branch_addr;
   logic [4:0]    wreg_address;
   logic          do_branch;

   typedef struct {
      int           cyc;
      logic [W-1:0] res;
      logic [W-1:0] baddr;
      logic         dob;
      logic [4:0]   wa;
   } exp_t;

   exp_t         q[$];
   int           cyc = 0;
   int           busy_until = 0;
   int           n_tests = 0;
   int           n_fail = 0;
   logic [W-1:0] hi_m = '0, lo_m = '0;

   execute_mc #(.WIDTH(W)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .pc4(pc4), .register_rs(register_rs), .register_rt(register_rt),
      .sign_extend(sign_extend), .function_opcode(function_opcode), .aluop(aluop),
      .alusrc(alusrc), .regdst(regdst), .branch(branch), .wreg_rd(wreg_rd),
      .wreg_rt(wreg_rt), .out_valid(out_valid), .alu_result(alu_result),
      .branch_addr(branch_addr), .wreg_address(wreg_address), .do_branch(do_branch)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference model: results from plain 64-bit arithmetic on the operands.
   task automatic model(output exp_t e, output bit multi);
      logic [W-1:0] b, r;
      logic [63:0]  p;
      longint       sa, sb, qq, rr;
      b     = alusrc ? sign_extend : register_rt;
      multi = 1'b0;
      r     = '0;
      case (aluop)
         2'd0: r = register_rs + b;
         2'd1: r = register_rs - b;
         2'd2: begin
            case (function_opcode)
               6'h20: r = register_rs + b;
               6'h22: r = register_rs - b;
               6'h24: r = register_rs & b;
               6'h25: r = register_rs | b;
               6'h2A: r = ($signed(register_rs) < $signed(b)) ? 32'd1 : 32'd0;
               6'h2B: r = (register_rs < b) ? 32'd1 : 32'd0;
               6'h10: r = hi_m;
               6'h12: r = lo_m;
               6'h18, 6'h19: begin
                  multi = 1'b1;
                  if (function_opcode == 6'h18) begin
                     sa = $signed(register_rs);
                     sb = $signed(b);
                     p  = sa * sb;
                  end else begin
                     p = {32'b0, register_rs} * {32'b0, b};
                  end
                  hi_m = p[63:32];
                  lo_m = p[31:0];
                  r    = lo_m;
               end
`ifdef EXEC_DIV_EN
               6'h1A, 6'h1B: begin
                  multi = 1'b1;
                  if (b == '0) begin
                     lo_m = '1;
                     hi_m = register_rs;
                  end else begin
                     if (function_opcode == 6'h1A) begin
                        sa = $signed(register_rs);
                        sb = $signed(b);
                     end else begin
                        sa = {32'b0, register_rs};
                        sb = {32'b0, b};
                     end
                     qq   = sa / sb;
                     rr   = sa % sb;
                     lo_m = 32'(qq);
                     hi_m = 32'(rr);
                  end
                  r = lo_m;
               end
`endif
               default: r = '0;
            endcase
         end
         default: r = '0;
      endcase
      e.res   = r;
      e.baddr = pc4 + (sign_extend << 2);
      e.dob   = branch && ((register_rs - b) == '0);
      e.wa    = multi ? 5'd0 : (regdst ? wreg_rd : wreg_rt);
      e.cyc   = 0;
   endtask

   // Advance to the next falling edge and check outputs against the queue.
   task automatic tick();
      @(negedge clock);
      if (reset_n) begin
         check_val("in_ready", in_ready, cyc >= busy_until);
         if (q.size() > 0 && q[0].cyc == cyc) begin
            check_val("out_valid", out_valid, 1);
            check_val("alu_result", alu_result, q[0].res);
            check_val("branch_addr", branch_addr, q[0].baddr);
            check_val("do_branch", do_branch, q[0].dob);
            check_val("wreg_address", wreg_address, q[0].wa);
            void'(q.pop_front());
         end else begin
            check_val("out_valid_quiet", out_valid, 0);
         end
      end
   endtask

   task automatic garbage();
      in_valid        = 1'($urandom);
      register_rs     = $urandom;
      register_rt     = $urandom;
      sign_extend     = $urandom;
      pc4             = $urandom;
      function_opcode = 6'($urandom);
      aluop           = 2'($urandom);
      branch          = 1'($urandom);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         if (cyc < busy_until) garbage();
         else in_valid = 1'b0;
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                        input logic [W-1:0] rs, input logic [W-1:0] rt,
                        input logic [W-1:0] imm, input logic [W-1:0] pc,
                        input logic src, input logic rsel, input logic br);
      exp_t e;
      bit   multi;
      tick();
      while (cyc < busy_until) begin
         garbage();
         tick();
      end
      aluop = op; function_opcode = fn; register_rs = rs; register_rt = rt;
      sign_extend = imm; pc4 = pc; alusrc = src; regdst = rsel; branch = br;
      wreg_rd = 5'($urandom); wreg_rt = 5'($urandom);
      in_valid = 1'b1;
      model(e, multi);
      e.cyc = cyc + 1 + (multi ? W : 0);
      if (multi) busy_until = cyc + 1 + W;
      q.push_back(e);
   endtask

   function automatic logic [W-1:0] rand_val();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         6: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   logic [5:0] fn_tab [14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h10,
                               6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h3F, 6'h00};

   initial begin
      logic [1:0] op;
      logic [5:0] fn;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check_val("rst_alu_result", alu_result, 0);
      check_val("rst_branch_addr", branch_addr, 0);
      check_val("rst_wreg_address", wreg_address, 0);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_do_branch", do_branch, 0);
      check_val("rst_in_ready", in_ready, 1);
      reset_n = 1'b1;

      // Reset in the middle of a multiply, then HI must read back as 0.
      issue(2'd2, 6'h18, 32'd1234567, 32'd7654321, '0, '0, 1'b0, 1'b1, 1'b0);
      drain(5);
      #2 reset_n = 1'b0;
      #1;
      check_val("midmul_alu_result", alu_result, 0);
      check_val("midmul_branch_addr", branch_addr, 0);
      check_val("midmul_wreg_address", wreg_address, 0);
      check_val("midmul_out_valid", out_valid, 0);
      check_val("midmul_do_branch", do_branch, 0);
      check_val("midmul_in_ready", in_ready, 1);
      q.delete();
      busy_until = 0;
      hi_m = '0;
      lo_m = '0;
      in_valid = 1'b0;
      tick();
      check_val("midmul_in_ready_held", in_ready, 1);
      reset_n = 1'b1;
      issue(2'd2, 6'h10, $urandom, $urandom, '0, '0, 1'b0, 1'b1, 1'b0);

      // Back-to-back single-cycle ops.
      issue(2'd2, 6'h20, 32'd7, 32'd5, '0, 32'h40, 1'b0, 1'b1, 1'b0);
      issue(2'd2, 6'h2A, 32'hFFFF_FFFF, 32'd1, '0, 32'h44, 1'b0, 1'b1, 1'b0);
      issue(2'd2, 6'h2B, 32'hFFFF_FFFF, 32'd1, '0, 32'h48, 1'b0, 1'b1, 1'b0);

      // Signed multiply followed immediately by mfhi/mflo.
      issue(2'd2, 6'h18, 32'hFFFF_FFFD, 32'd4, '0, '0, 1'b0, 1'b1, 1'b0);
      issue(2'd2, 6'h10, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
      issue(2'd2, 6'h12, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);

      // Divides (single-cycle zero result when the divider is not built).
      issue(2'd2, 6'h1A, 32'hFFFF_FFF9, 32'd2, '0, '0, 1'b0, 1'b1, 1'b0);
      issue(2'd2, 6'h10, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
      issue(2'd2, 6'h1B, 32'd7, 32'd0, '0, '0, 1'b0, 1'b1, 1'b0);
      issue(2'd2, 6'h10, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
      issue(2'd2, 6'h12, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);

      // beq taken with a negative offset, then an unsupported funct.
      issue(2'd1, 6'h00, 32'd9, 32'd9, 32'hFFFF_FFFE, 32'h100, 1'b0, 1'b0, 1'b1);
      issue(2'd2, 6'h3F, $urandom, $urandom, '0, '0, 1'b0, 1'b1, 1'b0);
      drain(3);

      for (int i = 0; i < 160; i++) begin
         op = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd2;
         fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 13)];
         issue(op, fn, rand_val(), rand_val(),
               ($urandom_range(0, 1) == 0) ? rand_val() : $urandom,
               $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) drain($urandom_range(1, 3));
      end

      drain(W + 4);
      check_val("pending_results", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/execute_mc.md
# execute_mc

Multi-cycle, width-parametrised execute unit for the MIPS datapath. It extends the single-cycle ALU with the following:
- Registered outputs.
- A valid/ready input handshake.
- An iterative multiplier and divider with HI/LO registers, and `mfhi`/`mflo`.
- Signed and unsigned set-less-than.

It sits between decode and memory/writeback. Decode must hold its operands stable only in the cycle `in_valid && in_ready` is high.

## Interface
Parameters:
- `WIDTH`, default 32: datapath width. Even, ≥ 8.

Ports:
- `clock` in 1: the only clock. All state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands and controls are valid.
- `in_ready` out 1: unit can accept an instruction. Equals (state == IDLE).
- `pc4` in WIDTH: PC+4 of the instruction.
- `register_rs`, `register_rt` in WIDTH: register operands.
- `sign_extend` in WIDTH: sign-extended immediate.
- `function_opcode` in 6: R-type funct field.
- `aluop` in 2: 00 add, 01 subtract/branch, 10 R-type, 11 reserved.
- `alusrc`, `regdst`, `branch` in 1: same meaning as in the single-cycle datapath.
- `wreg_rd`, `wreg_rt` in 5: destination register candidates.
- `out_valid` out 1: one-cycle pulse. Result outputs are valid in that cycle.
- `alu_result` out WIDTH: registered result.
- `branch_addr` out WIDTH: registered, pc4 + (sign_extend << 2), truncated to WIDTH.
- `wreg_address` out 5: registered. `wreg_rd` if `regdst`, else `wreg_rt`. Forced to 0 for mult/multu/div/divu.
- `do_branch` out 1: registered, `branch` && (rs − B == 0).

## Operation
- B operand = `sign_extend` if `alusrc`, else `register_rt`.
- FSM states: IDLE, MUL, DIV.
- Handshake: the instruction is accepted on the edge where `in_valid && in_ready`. Inputs are ignored at all other times.
- Single-cycle ops (accepted in IDLE, FSM stays IDLE):
  - aluop 00: add.
  - aluop 01: subtract.
  - aluop 11: result 0.
  - aluop 10, by funct:
    - 100000: add.
    - 100010: sub.
    - 100100: and.
    - 100101: or.
    - 101010: slt, signed compare.
    - 101011: sltu, unsigned compare.
    - 010000: mfhi, result = HI.
    - 010010: mflo, result = LO.
    - Any other funct: result 0. `out_valid` still pulses.
  - Add and sub wrap modulo 2^WIDTH. No overflow detection.
- mult (011000) / multu (011001): IDLE→MUL.
  - Shift-add multiply, one bit per cycle, WIDTH iterations.
  - Signed mult operates on magnitudes and negates the 2·WIDTH product if the operand signs differ.
  - On completion: {HI,LO} = product, `alu_result` = LO, FSM → IDLE.
- div (011010) / divu (011011): IDLE→DIV.
  - Restoring division, one quotient bit per cycle, WIDTH iterations.
  - LO = quotient, HI = remainder.
  - Signed: quotient sign = sign(rs) xor sign(rt); remainder sign = sign(rs).
  - Divide by zero: LO = all ones, HI = rs. Same latency as a normal divide.
  - On completion: `alu_result` = LO.
- HI/LO change only on mult/div completion.
- `do_branch` and `branch_addr` are computed for every accepted instruction, using B from the `alusrc` mux.
- Iteration counter is $clog2(WIDTH)+1 bits. It loads WIDTH on accept and finishes when it reaches 0.

## Timing
- Reset (asynchronous, any state, including mid-multiply/divide):
  - FSM → IDLE. Any operation in flight is abandoned.
  - HI, LO, counter, `alu_result`, `branch_addr` = 0.
  - `wreg_address` = 0; `out_valid` = 0; `do_branch` = 0.
  - `in_ready` = 1.
- Single-cycle op accepted at edge k: `out_valid` = 1 in the cycle after edge k, together with its results.
- mult/div accepted at edge k:
  - `in_ready` = 0 from edge k until edge k+WIDTH.
  - At edge k+WIDTH: FSM → IDLE, `out_valid` = 1.
  - `in_ready` returns to 1 in that same cycle, so a new instruction can be accepted at edge k+WIDTH+1.
  - Latency = WIDTH+1 cycles.
- `mfhi`/`mflo` accepted in the cycle the completion `out_valid` is high sees the updated HI/LO.
- Back-to-back single-cycle ops give one result per cycle. `out_valid` is low in any cycle that follows no accept.
- Result outputs hold their last value between pulses.

## Configuration
- `EXEC_DIV_EN` defined: the DIV state, divider datapath and div/divu decoding are compiled in, as described above.
- Not defined:
  - No DIV state or divider logic.
  - funct 011010/011011 are treated as unsupported: single-cycle, result 0, HI/LO unchanged.
- mult/multu are always present.

## Test plan
- Reset asserted mid-MUL (WIDTH=32):
  - All outputs 0, `in_ready` = 1 while `reset_n` is low.
  - After release, `mfhi` returns 0.
- add 7 + 5, then back-to-back `slt` −1 < 1 and `sltu` 0xFFFFFFFF < 1 → `alu_result` 12, 1, 0 on three consecutive `out_valid` pulses.
- mult −3 × 4 accepted at edge k:
  - `in_ready` low for 32 cycles.
  - `out_valid` in the cycle after edge k+32.
  - Then `mfhi`/`mflo` → 0xFFFFFFFF / 0xFFFFFFF4.
- With `EXEC_DIV_EN`:
  - div −7 / 2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF.
  - divu 7 / 0 → LO 0xFFFFFFFF, HI 7.
  - Without the macro: div returns 0 in 1 cycle, HI/LO unchanged.
- beq with branch=1, rs = rt = 9, pc4 = 0x100, sign_extend = 0xFFFFFFFE → `do_branch` 1, `branch_addr` 0xF8.
- Unsupported funct 111111 with aluop 10 → `alu_result` 0, `out_valid` pulses once, FSM stays IDLE.
